// File: rtl/gb_video_out.sv
`timescale 1ns/1ps
// gb_video_out
// Display back-end for a Game Boy frame buffer. Generates VGA timing from a
// divided pixel tick, reads the frame buffer with integer-scaled and centred
// addressing, maps each 2-bit shade through a writable 4-entry RGB palette
// and shows a border colour outside the scaled window.
//
// Ports:
//   clock        sole clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   pal_we       palette write strobe, sampled every clock
//   pal_idx      palette entry to write
//   pal_rgb      {R,G,B} value to write
//   fb_pixel     shade returned by the frame buffer, RD_LATENCY ticks after
//                the address
//   fb_x, fb_y   frame-buffer read column / row (hold outside the window)
//   fb_rd_en     high on ticks whose address lies inside the scaled window
//   vga_hs/vs    syncs, active low
//   vga_r/g/b    pixel colour
//   vga_blank_n  high during active video
//   frame_start  one-clock pulse on the tick at h=0, v=0
module gb_video_out #(
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 144,
  parameter int SCALE      = 3,
  parameter int COLOR_W    = 4,
  parameter int CLK_DIV    = 2,
  parameter int RD_LATENCY = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter logic [3*COLOR_W-1:0] BORDER_RGB = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pal_we,
  input  logic [1:0]             pal_idx,
  input  logic [3*COLOR_W-1:0]   pal_rgb,
  input  logic [1:0]             fb_pixel,
  output logic [7:0]             fb_x,
  output logic [7:0]             fb_y,
  output logic                   fb_rd_en,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vga_blank_n,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_OFF   = (H_ACTIVE - SRC_W * SCALE) / 2;
  localparam int Y_OFF   = (V_ACTIVE - SRC_H * SCALE) / 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CRW     = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_BEG  = HW'(X_OFF);
  localparam logic [HW-1:0] X_END  = HW'(X_OFF + SRC_W * SCALE);
  // Column counter restarts one tick before the window; with no left margin
  // that is the last tick of the previous line.
  localparam logic [HW-1:0] X_RST  = HW'((X_OFF == 0) ? H_TOTAL - 1 : X_OFF - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_BEG  = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_END  = VW'(Y_OFF + SRC_H * SCALE);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);

  if (SRC_W * SCALE > H_ACTIVE || SRC_H * SCALE > V_ACTIVE) begin : g_bad_scale
    $error("gb_video_out: scaled source does not fit the active area");
  end

  // Default shade ramp: channel value (2^COLOR_W-1)*(3-i)/3, same on R,G,B.
  function automatic logic [CRW-1:0] pal_default(input int i);
    int c;
    c = (((1 << COLOR_W) - 1) * (3 - i)) / 3;
    return {3{COLOR_W'(c)}};
  endfunction

  logic [DW-1:0]  div_q;
  logic           tick;
  logic [HW-1:0]  h_q;
  logic [VW-1:0]  v_q;
  logic [SW-1:0]  sx_q, sy_q;
  logic [7:0]     x_cnt, y_cnt;
  logic           in_x, in_y, in_win, active, hs_act, vs_act;
  logic [1:0]     pix_q;
  logic [CRW-1:0] rgb_q, rgb_next;
  logic [CRW-1:0] pal [4];
  // {hs_act, vs_act, active}; stage 0 is the address stage.
  logic [2:0]     sync_dly [RD_LATENCY+2];
  logic           win_dly  [RD_LATENCY+1];

  assign tick   = (div_q == DIV_LAST);
  assign in_x   = (h_q >= X_BEG) && (h_q < X_END);
  assign in_y   = (v_q >= Y_BEG) && (v_q < Y_END);
  assign in_win = in_x && in_y;
  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_act = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act = (v_q >= VS_BEG) && (v_q < VS_END);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= tick ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= '0;
      v_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_rd_en <= 1'b0;
      pix_q    <= '0;
      rgb_q    <= '0;
      for (int i = 0; i < RD_LATENCY + 2; i++) sync_dly[i] <= '0;
      for (int i = 0; i < RD_LATENCY + 1; i++) win_dly[i]  <= 1'b0;
    end else if (tick) begin
      // Raster counters
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_q <= h_q + HW'(1);
      end

      // Column scaling: fb column advances every SCALE ticks in the window.
      if (h_q == X_RST) begin
        sx_q  <= '0;
        x_cnt <= '0;
      end else if (in_x) begin
        if (sx_q == S_LAST) begin
          sx_q  <= '0;
          x_cnt <= x_cnt + 8'd1;
        end else begin
          sx_q <= sx_q + SW'(1);
        end
      end

      // Row scaling at line end; cleared at the end of the frame so the next
      // frame starts from row 0.
      if (h_q == H_LAST) begin
        if (v_q == V_LAST) begin
          sy_q  <= '0;
          y_cnt <= '0;
        end else if (in_y) begin
          if (sy_q == S_LAST) begin
            sy_q  <= '0;
            y_cnt <= y_cnt + 8'd1;
          end else begin
            sy_q <= sy_q + SW'(1);
          end
        end
      end

      // Address stage: address for the current raster position.
      fb_rd_en <= in_win;
      if (in_win) begin
        fb_x <= x_cnt;
        fb_y <= y_cnt;
      end

      sync_dly[0] <= {hs_act, vs_act, active};
      for (int i = 1; i < RD_LATENCY + 2; i++) sync_dly[i] <= sync_dly[i-1];
      win_dly[0] <= in_win;
      for (int i = 1; i < RD_LATENCY + 1; i++) win_dly[i] <= win_dly[i-1];

      // Shade arrives RD_LATENCY ticks after its address; colour is loaded
      // one tick later together with the last sync stage.
      pix_q <= fb_pixel;
      rgb_q <= rgb_next;
    end
  end

  // Palette writes are not gated by tick; a write on the same edge as a
  // colour load still lets that load see the old entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) pal[i] <= pal_default(i);
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

  always_comb begin
    rgb_next = '0;
    if (sync_dly[RD_LATENCY][0]) begin
      rgb_next = win_dly[RD_LATENCY] ? pal[pix_q] : BORDER_RGB;
    end
  end

  assign vga_hs      = ~sync_dly[RD_LATENCY+1][2];
  assign vga_vs      = ~sync_dly[RD_LATENCY+1][1];
  assign vga_blank_n =  sync_dly[RD_LATENCY+1][0];
  assign vga_r       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b       = rgb_q[COLOR_W-1:0];
  // Gated by reset_n so the pulse stays low in reset even when CLK_DIV=1.
  assign frame_start = reset_n && tick && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_gb_video_out.sv
`timescale 1ns/1ps
// Testbench for gb_video_out. Default horizontal timing and scaling, with a
// shortened vertical frame (SRC_H=4, 16 active lines, 23 lines total) so a
// whole frame fits in a short run, and a blue border colour.
module tb_gb_video_out;

  localparam int DIV     = 2;
  localparam int HT      = 800;        // 640+16+96+48
  localparam int VT      = 23;         // 16+2+2+3
  localparam int FRAME_T = HT * VT;    // 18400 ticks
  localparam int XO      = 80;         // (640-480)/2
  localparam int XE      = 560;
  localparam int YO      = 2;          // (16-12)/2
  localparam int YE      = 14;
  localparam int VA      = 16;
  localparam logic [11:0] BORDER = 12'h00F;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_idx = 2'd0;
  logic [11:0] pal_rgb = 12'd0;
  logic [1:0]  fb_pixel;
  logic [7:0]  fb_x, fb_y;
  logic        fb_rd_en, vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;

  always #5 clock = ~clock;

  gb_video_out #(
    .SRC_W(160), .SRC_H(4), .SCALE(3), .COLOR_W(4), .CLK_DIV(DIV), .RD_LATENCY(2),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .BORDER_RGB(BORDER)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .fb_pixel(fb_pixel),
    .fb_x(fb_x), .fb_y(fb_y), .fb_rd_en(fb_rd_en),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_blank_n(vga_blank_n), .frame_start(frame_start)
  );

  // Frame-buffer model: two-tick read latency, returns fb_x[1:0] as shade.
  int         bdiv;
  logic [7:0] ram_q;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bdiv  <= 0;
      ram_q <= 8'd0;
    end else if (bdiv == DIV - 1) begin
      bdiv  <= 0;
      ram_q <= fb_x;
    end else begin
      bdiv <= bdiv + 1;
    end
  end
  assign fb_pixel = ram_q[1:0];

  int total = 0;
  int bad   = 0;
  int c     = 0;   // clock edges since the last reset release
  logic [11:0] exp_pal [4];
  logic [3:0]  r_tab [4];

  // driver tasks
  task automatic do_reset();
    reset_n = 1'b0;
    pal_we  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    c = 0;
    exp_pal[0] = 12'hFFF; exp_pal[1] = 12'hAAA;
    exp_pal[2] = 12'h555; exp_pal[3] = 12'h000;
  endtask

  task automatic tick_clock();
    @(posedge clock);
    #1;
    c++;
  endtask

  // Advance until the colour outputs show stream position po (row-major,
  // counted from the release); the output trails the raster by 4 ticks.
  task automatic run_to_out(input int po);
    while (c < DIV * (po + 4)) tick_clock();
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3600) tick_clock();   // address at h=199,v=2 -> fb_x=39
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({vga_hs, vga_vs, vga_blank_n} !== 3'b110) begin
      bad++; $display("FAIL reset_sync got=%b want=110", {vga_hs, vga_vs, vga_blank_n});
    end
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      bad++; $display("FAIL reset_rgb got=%h want=000", {vga_r, vga_g, vga_b});
    end
    total++;
    if ({fb_x, fb_y, fb_rd_en, frame_start} !== 18'd0) begin
      bad++; $display("FAIL reset_addr got x=%0d y=%0d en=%b fs=%b want all 0",
                      fb_x, fb_y, fb_rd_en, frame_start);
    end
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, fb_x, fb_y, fb_rd_en} !== {3'b110, 12'h000, 17'd0}) begin
      bad++; $display("FAIL reset_hold got hs=%b vs=%b bn=%b rgb=%h x=%0d", vga_hs, vga_vs,
                      vga_blank_n, {vga_r, vga_g, vga_b}, fb_x);
    end
    @(negedge clock);
    reset_n = 1'b1;
    c = 0;
    #1;
    total++;
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL fs_at_release got=%b want=0", frame_start);
    end
    tick_clock();
    total++;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL fs_first_tick got=%b want=1", frame_start);
    end
    tick_clock();
    total++;
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL fs_one_clock got=%b want=0", frame_start);
    end
  endtask

  task automatic test_frame_scan();
    int hold_x, hold_y, k, pa, ha, va, po, ho, vo;
    logic ewin, eact, ehs, evs, efs, prev_hs, prev_vs;
    logic [11:0] ergb;
    int hs_f1, hs_f2, hs_r1, vs_f1, vs_r1, fs1, fs2;
    hold_x = 0; hold_y = 0;
    hs_f1 = -1; hs_f2 = -1; hs_r1 = -1; vs_f1 = -1; vs_r1 = -1; fs1 = -1; fs2 = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    do_reset();
    for (int cc = 1; cc <= DIV * (FRAME_T + 4); cc++) begin
      tick_clock();
      efs = (c % DIV == 1) && ((((c - 1) / DIV) % FRAME_T) == 0);
      total++;
      if (frame_start !== efs) begin
        bad++; $display("FAIL frame_start clk=%0d got=%b want=%b", c, frame_start, efs);
      end
      if (frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
      end
      if (prev_hs && !vga_hs) begin
        if (hs_f1 < 0) hs_f1 = c; else if (hs_f2 < 0) hs_f2 = c;
      end
      if (!prev_hs && vga_hs && hs_r1 < 0 && hs_f1 >= 0) hs_r1 = c;
      if (prev_vs && !vga_vs && vs_f1 < 0) vs_f1 = c;
      if (!prev_vs && vga_vs && vs_r1 < 0 && vs_f1 >= 0) vs_r1 = c;
      prev_hs = vga_hs; prev_vs = vga_vs;

      if (c % DIV == 0) begin
        k  = c / DIV;
        pa = k - 1;
        ha = pa % HT;
        va = (pa / HT) % VT;
        ewin = (ha >= XO) && (ha < XE) && (va >= YO) && (va < YE);
        if (ewin) begin
          hold_x = (ha - XO) / 3;
          hold_y = (va - YO) / 3;
        end
        total++;
        if ({fb_x, fb_y, fb_rd_en} !== {hold_x[7:0], hold_y[7:0], ewin}) begin
          bad++; $display("FAIL addr h=%0d v=%0d got x=%0d y=%0d en=%b want x=%0d y=%0d en=%b",
                          ha, va, fb_x, fb_y, fb_rd_en, hold_x, hold_y, ewin);
        end
        if (pa == YO * HT + 80) begin
          total++;
          if ({fb_x, fb_y, fb_rd_en} !== {8'd0, 8'd0, 1'b1}) begin
            bad++; $display("FAIL win_first got x=%0d y=%0d en=%b want 0 0 1", fb_x, fb_y, fb_rd_en);
          end
        end
        if (pa == (YE - 1) * HT + 559) begin
          total++;
          if ({fb_x, fb_y} !== {8'd159, 8'd3}) begin
            bad++; $display("FAIL win_last got x=%0d y=%0d want 159 3", fb_x, fb_y);
          end
        end
        if (pa == YO * HT + 79 || pa == YO * HT + 560) begin
          total++;
          if (fb_rd_en !== 1'b0) begin
            bad++; $display("FAIL rd_en_edge h=%0d got=%b want=0", ha, fb_rd_en);
          end
        end

        if (k >= 4) begin
          po = k - 4;
          ho = po % HT;
          vo = (po / HT) % VT;
          eact = (ho < 640) && (vo < VA);
          ehs  = !((ho >= 656) && (ho < 752));
          evs  = !((vo >= 18) && (vo < 20));
          if (!eact) ergb = 12'h000;
          else if ((ho >= XO) && (ho < XE) && (vo >= YO) && (vo < YE))
            ergb = exp_pal[((ho - XO) / 3) % 4];
          else ergb = BORDER;
        end else begin
          ho = -1; vo = -1;
          eact = 1'b0; ehs = 1'b1; evs = 1'b1; ergb = 12'h000;
        end
        total++;
        if ({vga_hs, vga_vs, vga_blank_n} !== {ehs, evs, eact}) begin
          bad++; $display("FAIL sync h=%0d v=%0d got hs=%b vs=%b bn=%b want hs=%b vs=%b bn=%b",
                          ho, vo, vga_hs, vga_vs, vga_blank_n, ehs, evs, eact);
        end
        total++;
        if ({vga_r, vga_g, vga_b} !== ergb) begin
          bad++; $display("FAIL rgb h=%0d v=%0d got=%h want=%h", ho, vo, {vga_r, vga_g, vga_b}, ergb);
        end
        if (vo == YO && ho >= 80 && ho < 92) begin
          total++;
          if (vga_r !== r_tab[(ho - 80) / 3]) begin
            bad++; $display("FAIL align_r h=%0d got=%h want=%h", ho, vga_r, r_tab[(ho - 80) / 3]);
          end
        end
      end
    end
    total++;
    if (hs_r1 - hs_f1 !== 192) begin
      bad++; $display("FAIL hs_low got=%0d want=192 clocks", hs_r1 - hs_f1);
    end
    total++;
    if (hs_f2 - hs_f1 !== 1600) begin
      bad++; $display("FAIL hs_period got=%0d want=1600 clocks", hs_f2 - hs_f1);
    end
    total++;
    if (vs_r1 - vs_f1 !== 3200) begin
      bad++; $display("FAIL vs_low got=%0d want=3200 clocks", vs_r1 - vs_f1);
    end
    total++;
    if (fs2 - fs1 !== 36800) begin
      bad++; $display("FAIL frame_period got=%0d want=36800 clocks", fs2 - fs1);
    end
  endtask

  // Runs on from the end of the frame scan into line YO of the second frame.
  task automatic test_palette_write();
    int base;
    base = FRAME_T + YO * HT;
    while (c < DIV * (base + 80 + 4) - 1) tick_clock();
    pal_we = 1'b1; pal_idx = 2'd0; pal_rgb = 12'h123;
    tick_clock();                  // write shares the edge with the h=80 load
    pal_we = 1'b0;
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
      bad++; $display("FAIL pal_concurrent got=%h want=FFF", {vga_r, vga_g, vga_b});
    end
    run_to_out(base + 81);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h123) begin
      bad++; $display("FAIL pal_new0 got=%h want=123", {vga_r, vga_g, vga_b});
    end
    run_to_out(base + 85);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'hAAA) begin
      bad++; $display("FAIL pal_keep1 got=%h want=AAA", {vga_r, vga_g, vga_b});
    end
    pal_we = 1'b1; pal_idx = 2'd1; pal_rgb = 12'h456;
    tick_clock();                  // non-tick clock
    pal_we = 1'b0;
    run_to_out(base + 86);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h555) begin
      bad++; $display("FAIL pal_keep2 got=%h want=555", {vga_r, vga_g, vga_b});
    end
    run_to_out(base + 92);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h123) begin
      bad++; $display("FAIL pal_new0_later got=%h want=123", {vga_r, vga_g, vga_b});
    end
    run_to_out(base + 95);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h456) begin
      bad++; $display("FAIL pal_new1 got=%h want=456", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_reset_revert();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({vga_blank_n, vga_r, vga_g, vga_b} !== 13'd0) begin
      bad++; $display("FAIL revert_async got bn=%b rgb=%h want 0 000", vga_blank_n, {vga_r, vga_g, vga_b});
    end
    do_reset();
    run_to_out(YO * HT + 80);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
      bad++; $display("FAIL revert_pal0 got=%h want=FFF", {vga_r, vga_g, vga_b});
    end
    run_to_out(YO * HT + 83);
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'hAAA) begin
      bad++; $display("FAIL revert_pal1 got=%h want=AAA", {vga_r, vga_g, vga_b});
    end
  endtask

  initial begin
    r_tab[0] = 4'hF; r_tab[1] = 4'hA; r_tab[2] = 4'h5; r_tab[3] = 4'h0;
    test_reset();
    test_frame_scan();
    test_palette_write();
    test_reset_revert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gb_video_out.md
# gb_video_out

Parametrised display back-end that replaces the fixed VGA-timing, fixed-palette, unscaled framebuffer read path. It generates VGA timing from a divided pixel tick and reads the Game Boy frame buffer with integer-scaled, centred addressing. It maps each 2-bit shade through a CPU-writable 4-entry RGB palette and drives border colour outside the scaled window. All sync and colour outputs are aligned to the frame-buffer read latency.

## Interface
- SRC_W, 160, source frame width in pixels
- SRC_H, 144, source frame height in lines
- SCALE, 3, integer scale factor (≥1)
- COLOR_W, 4, bits per colour channel
- CLK_DIV, 2, clocks per pixel tick (≥1)
- RD_LATENCY, 2, frame-buffer read latency in pixel ticks (≥1)
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel ticks
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
- BORDER_RGB, 0, {R,G,B} colour outside the scaled window
- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pal_we  in  1  palette write strobe
- pal_idx  in  2  palette entry to write
- pal_rgb  in  3*COLOR_W  {R,G,B} value to write
- fb_pixel  in  2  shade returned by the frame buffer
- fb_x  out  8  frame-buffer read column
- fb_y  out  8  frame-buffer read row
- fb_rd_en  out  1  high on ticks whose address lies inside the scaled window
- vga_hs, vga_vs  out  1  syncs, active low
- vga_r, vga_g, vga_b  out  COLOR_W  pixel colour
- vga_blank_n  out  1  high during active video
- frame_start  out  1  one-clock pulse at tick with h=0, v=0

## Operation
- Tick divider: counter 0..CLK_DIV-1. The pixel tick is asserted when the counter = CLK_DIV-1. Every counter and pipeline stage advances only on a tick.
- h counter 0..H_TOTAL-1 (H_TOTAL = sum of H_*). v counter increments when h wraps and wraps at V_TOTAL.
- Active area: h<H_ACTIVE, v<V_ACTIVE. Sync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vertical sync is defined the same way on v.
- Window: X_OFF=(H_ACTIVE-SRC_W*SCALE)/2, Y_OFF=(V_ACTIVE-SRC_H*SCALE)/2, computed at elaboration. The window is X_OFF ≤ h < X_OFF+SRC_W*SCALE, with the same rule on v.
- Scaling uses no divider:
  - sub-counters sx, sy run 0..SCALE-1.
  - fb_x increments when sx wraps. fb_x is reset to 0 at h=X_OFF-1 (or at line start when X_OFF=0).
  - fb_y increments when sy wraps at line end inside the window. fb_y and sy are reset at frame start.
- fb_x and fb_y hold their last value outside the window. fb_rd_en=0 outside the window.
- Palette: 4 entries × 3*COLOR_W. Reset values are F/A/5/0 per channel for COLOR_W=4, generally (2^COLOR_W-1)·(3-i)/3 truncated.
  - pal_we is sampled every clock, independent of tick.
  - A write in clock n affects pixels output from clock n+1.
- Colour selection: blank → 0. Active and outside the window → BORDER_RGB. Inside the window → palette[fb_pixel].

## Timing
- Address stage: fb_x, fb_y and fb_rd_en are registered and update on tick t for screen position (h,v) of tick t.
- fb_pixel for that address must be valid at tick t+RD_LATENCY. The module samples it there and registers the colour at tick t+RD_LATENCY+1.
- vga_hs, vga_vs, vga_blank_n and the window flag travel through a RD_LATENCY+1-tick delay line. Sync-to-colour alignment is therefore exact.
- frame_start is a single clock, not a full tick, undelayed.
- Reset values: vga_hs=vga_vs=1, rgb=0, vga_blank_n=0, fb_x=fb_y=0, fb_rd_en=0, frame_start=0, all counters and delay lines 0, palette at defaults.
- The first frame_start occurs on the first tick after release.
- Reset mid-frame forces the reset values immediately, asynchronously. The frame restarts at h=v=0. The palette also reverts.
- A palette write concurrent with a tick uses the old entry for that tick's colour register load.
- SCALE with SRC_W*SCALE>H_ACTIVE or SRC_H*SCALE>V_ACTIVE is an elaboration error.

## Test plan
- Reset: hold reset_n=0 mid-frame → all outputs at reset values. Release → frame_start pulses on the first tick, i.e. clock CLK_DIV-1 after release.
- Horizontal timing: default parameters → vga_hs low for 192 clocks, period 1600 clocks. vga_vs low for 2 lines = 3200 clocks, frame = 525 lines.
- Scaling/addressing: tick at (h=80, v=24) → fb_x=0, fb_y=0. Each fb_x value is held 3 ticks. Tick at (559, 455) → (159, 143). fb_rd_en is 0 at h=79 and at h=560.
- Pipeline alignment: bench RAM with RD_LATENCY=2 returning fb_x[1:0] → vga_r shows F,A,5,0 in 3-pixel groups starting exactly at the first blank_n-high column +80.
- Border/blank: BORDER_RGB=12'h00F → rgb=00F at active h=0..79. rgb=0 whenever vga_blank_n=0.
- Palette write: write pal_idx=0, pal_rgb=12'h123 mid-line → subsequent shade-0 pixels output 123. Reset → entry 0 reads FFF again.
